// File: rtl/v_alu_seq.sv
// v_alu_seq: operand sequencer in front of the VALU.
// Takes whole vector operands, feeds the VALU one 32-bit chunk per cycle and
// tracks the per-op result latency (add/sub go through a registered adder).
// It then reassembles the returned chunks into vd_data and pulses done
// when the last chunk has landed.
// Optional feature macro: V_ALU_SEQ_SCALAR_EN (scalar operand B from rs1_data).
//
// Handshake: start is only looked at while busy=0. An accepted start is
// committed; no back-pressure exists. done is a one-cycle pulse. busy is
// already low in that cycle, so a new start there is accepted back-to-back.
module v_alu_seq #(
   parameter int VECTOR_LENGTH = 128,
   parameter int VALU_OP_W_MAX = 32,
   parameter int ADDSUB_LAT    = 1
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     start,
   input  logic [3:0]               op_instr,
   input  logic [1:0]               vsew,
   input  logic [VECTOR_LENGTH-1:0] vs2_data,
   input  logic [VECTOR_LENGTH-1:0] vs1_data,
`ifdef V_ALU_SEQ_SCALAR_EN
   input  logic                     scalar_sel,
   input  logic [31:0]              rs1_data,
`endif
   output logic                     busy,
   output logic                     done,
   output logic [VECTOR_LENGTH-1:0] vd_data,
   output logic [3:0]               alu_op_instr,
   output logic [1:0]               alu_vsew,
   output logic [VALU_OP_W_MAX-1:0] alu_op_A,
   output logic [VALU_OP_W_MAX-1:0] alu_op_B,
   input  logic [VALU_OP_W_MAX-1:0] alu_result
);

   localparam int N     = VECTOR_LENGTH / VALU_OP_W_MAX;
   localparam int W     = VALU_OP_W_MAX;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   // Valid pipe depth; one flop minimum even when no op has latency.
   localparam int SR_W  = (ADDSUB_LAT > 0) ? ADDSUB_LAT : 1;
   localparam int CNT_W = (SR_W > 1) ? $clog2(SR_W) : 1;

   localparam logic [3:0] VALU_VADD = 4'd0;
   localparam logic [3:0] VALU_VSUB = 4'd1;
`ifdef V_ALU_SEQ_SCALAR_EN
   localparam logic [1:0] VSEW_8  = 2'd0;
   localparam logic [1:0] VSEW_16 = 2'd1;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         issue_idx_q, issue_idx_d;
   logic [IDX_W-1:0]         cap_idx_q, cap_idx_d;
   logic [CNT_W-1:0]         drain_cnt_q, drain_cnt_d;
   logic [3:0]               op_q, op_d;
   logic [1:0]               vsew_q, vsew_d;
   logic [VECTOR_LENGTH-1:0] vs2_q, vs2_d;
   logic [VECTOR_LENGTH-1:0] vs1_q, vs1_d;
   logic [SR_W-1:0]          valid_sr_q, valid_sr_d;
   logic [VECTOR_LENGTH-1:0] vd_q, vd_d;
   logic                     done_q, done_d;
`ifdef V_ALU_SEQ_SCALAR_EN
   logic                     scalar_sel_q, scalar_sel_d;
   logic [31:0]              rs1_q, rs1_d;
   logic [W-1:0]             scalar_b;
`endif

   logic         issuing;
   logic         lat_sel;
   logic         last_issue;
   logic         cap_valid;
   logic [W-1:0] chunk_a;
   logic [W-1:0] chunk_b;

   assign issuing    = (state_q == ST_ISSUE);
   // Only add/sub see the registered adder; everything else returns same cycle.
   assign lat_sel    = (ADDSUB_LAT > 0) && ((op_q == VALU_VADD) || (op_q == VALU_VSUB));
   assign last_issue = (issue_idx_q == IDX_W'(N - 1));
   assign cap_valid  = lat_sel ? valid_sr_q[SR_W-1] : issuing;

`ifdef V_ALU_SEQ_SCALAR_EN
   // Replicate rs1 across the 32-bit chunk at the latched element width.
   always_comb begin
      scalar_b = '0;
      case (vsew_q)
         VSEW_8:  scalar_b = {4{rs1_q[7:0]}};
         VSEW_16: scalar_b = {2{rs1_q[15:0]}};
         default: scalar_b = rs1_q;
      endcase
   end
`endif

   // Select the operand chunks addressed by issue_idx.
   always_comb begin
      chunk_a = '0;
      chunk_b = '0;
      for (int k = 0; k < N; k++) begin
         if (issue_idx_q == IDX_W'(k)) begin
            chunk_a = vs2_q[k*W +: W];
            chunk_b = vs1_q[k*W +: W];
         end
      end
`ifdef V_ALU_SEQ_SCALAR_EN
      if (scalar_sel_q) begin
         chunk_b = scalar_b;
      end
`endif
   end

   // Next-state: FSM, operand latching, latency pipe and result capture.
   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      cap_idx_d   = cap_idx_q;
      drain_cnt_d = drain_cnt_q;
      op_d        = op_q;
      vsew_d      = vsew_q;
      vs2_d       = vs2_q;
      vs1_d       = vs1_q;
      vd_d        = vd_q;
      done_d      = 1'b0;
      valid_sr_d  = SR_W'({valid_sr_q, issuing & lat_sel});
`ifdef V_ALU_SEQ_SCALAR_EN
      scalar_sel_d = scalar_sel_q;
      rs1_d        = rs1_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d        = op_instr;
               vsew_d      = vsew;
               vs2_d       = vs2_data;
               vs1_d       = vs1_data;
               issue_idx_d = '0;
               cap_idx_d   = '0;
               drain_cnt_d = '0;
`ifdef V_ALU_SEQ_SCALAR_EN
               scalar_sel_d = scalar_sel;
               rs1_d        = rs1_data;
`endif
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue_idx_d = issue_idx_q + IDX_W'(1);
            if (last_issue) begin
               drain_cnt_d = '0;
               state_d     = lat_sel ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Hold op/vsew so the VALU keeps clocking the adder pipeline out.
            if (drain_cnt_q == CNT_W'(SR_W - 1)) begin
               state_d = ST_IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A returned chunk lands in its slot; the last one raises done.
      if (cap_valid) begin
         for (int k = 0; k < N; k++) begin
            if (cap_idx_q == IDX_W'(k)) begin
               vd_d[k*W +: W] = alu_result;
            end
         end
         cap_idx_d = cap_idx_q + IDX_W'(1);
         if (cap_idx_q == IDX_W'(N - 1)) begin
            done_d = 1'b1;
         end
      end
   end

   // State register and datapath flops, cleared asynchronously by nrst.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         issue_idx_q <= '0;
         cap_idx_q   <= '0;
         drain_cnt_q <= '0;
         op_q        <= '0;
         vsew_q      <= '0;
         vs2_q       <= '0;
         vs1_q       <= '0;
         valid_sr_q  <= '0;
         vd_q        <= '0;
         done_q      <= 1'b0;
`ifdef V_ALU_SEQ_SCALAR_EN
         scalar_sel_q <= 1'b0;
         rs1_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         issue_idx_q <= issue_idx_d;
         cap_idx_q   <= cap_idx_d;
         drain_cnt_q <= drain_cnt_d;
         op_q        <= op_d;
         vsew_q      <= vsew_d;
         vs2_q       <= vs2_d;
         vs1_q       <= vs1_d;
         valid_sr_q  <= valid_sr_d;
         vd_q        <= vd_d;
         done_q      <= done_d;
`ifdef V_ALU_SEQ_SCALAR_EN
         scalar_sel_q <= scalar_sel_d;
         rs1_q        <= rs1_d;
`endif
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign vd_data      = vd_q;
   assign alu_op_instr = op_q;
   assign alu_vsew     = vsew_q;
   assign alu_op_A     = issuing ? chunk_a : '0;
   assign alu_op_B     = issuing ? chunk_b : '0;

endmodule

// File: tb/tb_v_alu_seq.sv
// tb_v_alu_seq: bench for v_alu_seq with a behavioural VALU
// (registered add/sub, combinational logic ops).
module tb_v_alu_seq;

   localparam int VL = 128;
   localparam int W  = 32;
   localparam int N  = VL / W;
   localparam int NVEC = 10;

   localparam logic [3:0] VALU_VADD = 4'd0;
   localparam logic [3:0] VALU_VSUB = 4'd1;
   localparam logic [3:0] VALU_VAND = 4'd2;
   localparam logic [3:0] VALU_VOR  = 4'd3;
   localparam logic [3:0] VALU_VXOR = 4'd4;
   localparam logic [1:0] VSEW_8  = 2'd0;
   localparam logic [1:0] VSEW_16 = 2'd1;
   localparam logic [1:0] VSEW_32 = 2'd2;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op_instr = '0;
   logic [1:0]    vsew = '0;
   logic [VL-1:0] vs2_data = '0;
   logic [VL-1:0] vs1_data = '0;
`ifdef V_ALU_SEQ_SCALAR_EN
   logic          scalar_sel = 1'b0;
   logic [31:0]   rs1_data = '0;
`endif
   logic          busy;
   logic          done;
   logic [VL-1:0] vd_data;
   logic [3:0]    alu_op_instr;
   logic [1:0]    alu_vsew;
   logic [W-1:0]  alu_op_A;
   logic [W-1:0]  alu_op_B;
   logic [W-1:0]  alu_result;
   logic [W-1:0]  add_q = '0;

   int errors = 0;
   int checks = 0;
   logic [VL-1:0] exp_q[$];
   logic [VL-1:0] sb_exp;

   typedef struct {
      logic [3:0]    op;
      logic [1:0]    sew;
      logic [VL-1:0] a;
      logic [VL-1:0] b;
      logic [VL-1:0] exp;
   } vec_t;
   vec_t tbl [NVEC];

   v_alu_seq #(.VECTOR_LENGTH(VL), .VALU_OP_W_MAX(W), .ADDSUB_LAT(1)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .op_instr     (op_instr),
      .vsew         (vsew),
      .vs2_data     (vs2_data),
      .vs1_data     (vs1_data),
`ifdef V_ALU_SEQ_SCALAR_EN
      .scalar_sel   (scalar_sel),
      .rs1_data     (rs1_data),
`endif
      .busy         (busy),
      .done         (done),
      .vd_data      (vd_data),
      .alu_op_instr (alu_op_instr),
      .alu_vsew     (alu_vsew),
      .alu_op_A     (alu_op_A),
      .alu_op_B     (alu_op_B),
      .alu_result   (alu_result)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic is_addsub(input logic [3:0] op);
      return (op == VALU_VADD) || (op == VALU_VSUB);
   endfunction

   // Lane-wise VALU behaviour on one 32-bit chunk.
   function automatic logic [W-1:0] valu_model(input logic [3:0] op, input logic [1:0] sew,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      case (op)
         VALU_VAND: r = a & b;
         VALU_VOR:  r = a | b;
         VALU_VXOR: r = a ^ b;
         VALU_VADD, VALU_VSUB: begin
            case (sew)
               VSEW_8:
                  for (int i = 0; i < 4; i++)
                     r[i*8 +: 8] = (op == VALU_VADD) ? a[i*8 +: 8] + b[i*8 +: 8] : a[i*8 +: 8] - b[i*8 +: 8];
               VSEW_16:
                  for (int i = 0; i < 2; i++)
                     r[i*16 +: 16] = (op == VALU_VADD) ? a[i*16 +: 16] + b[i*16 +: 16] : a[i*16 +: 16] - b[i*16 +: 16];
               default:
                  r = (op == VALU_VADD) ? a + b : a - b;
            endcase
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [VL-1:0] vec_model(input logic [3:0] op, input logic [1:0] sew,
                                               input logic [VL-1:0] a, input logic [VL-1:0] b);
      logic [VL-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++)
         r[k*W +: W] = valu_model(op, sew, a[k*W +: W], b[k*W +: W]);
      return r;
   endfunction

   // Behavioural VALU: add/sub registered one cycle, others combinational.
   always @(posedge clk) add_q <= valu_model(alu_op_instr, alu_vsew, alu_op_A, alu_op_B);
   assign alu_result = is_addsub(alu_op_instr) ? add_q : valu_model(alu_op_instr, alu_vsew, alu_op_A, alu_op_B);

   task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: every done pops the oldest expected vector.
   always @(negedge clk) begin
      if (nrst === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: done seen, actual=unexpected required=no done");
         end else begin
            sb_exp = exp_q.pop_front();
            chk("scoreboard vd_data", vd_data, sb_exp);
         end
      end
   end

   // Observe cycles first_c..last_c (entered at the negedge of first_c) of an
   // op whose start was sampled in start_c; ends at the negedge of last_c.
   task automatic watch(input string name, input int start_c, input int first_c,
                        input int last_c, input int lat);
      int exp_done;
      int n_done;
      int done_c;
      int busy_ok;
      int opab_ok;
      exp_done = start_c + N + lat + 1;
      n_done = 0;
      done_c = -1;
      busy_ok = 1;
      opab_ok = 1;
      for (int c = first_c; c <= last_c; c++) begin
         if (busy !== ((c > start_c) && (c < exp_done))) busy_ok = 0;
         if (((c <= start_c) || (c > start_c + N)) && ((alu_op_A !== '0) || (alu_op_B !== '0))) opab_ok = 0;
         if (done === 1'b1) begin
            n_done++;
            if (done_c < 0) done_c = c;
         end
         if (c < last_c) @(negedge clk);
      end
      chk_int({name, " done_cycle"}, done_c, exp_done);
      chk_int({name, " done_count"}, n_done, 1);
      chk_int({name, " busy_window"}, busy_ok, 1);
      chk_int({name, " opAB_zero_outside_issue"}, opab_ok, 1);
   endtask

   // Drive one op at the current negedge (cycle 0) and follow it to idle.
   task automatic run_vec(input string name, input logic [3:0] op, input logic [1:0] sew,
                          input logic [VL-1:0] a, input logic [VL-1:0] b, input logic [VL-1:0] exp);
      int lat;
      lat = is_addsub(op) ? 1 : 0;
      op_instr = op;
      vsew = sew;
      vs2_data = a;
      vs1_data = b;
      start = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      watch(name, 0, 1, N + lat + 3, lat);
      chk_int({name, " op_instr_held"}, alu_op_instr, op);
      chk_int({name, " vsew_held"}, alu_vsew, sew);
      @(negedge clk);
   endtask

   // Main sequence
   initial begin
      int n_done;

      tbl[0] = '{VALU_VADD, VSEW_8,  {16{8'h01}}, {16{8'h02}}, {16{8'h03}}};
      tbl[1] = '{VALU_VAND, VSEW_32, {4{32'hFFFF0000}}, {4{32'h0F0F0F0F}}, {4{32'h0F0F0000}}};
      tbl[2] = '{VALU_VSUB, VSEW_16, {8{16'h0010}}, {8{16'h0003}}, {8{16'h000D}}};
      tbl[3] = '{VALU_VOR,  VSEW_32, 128'h00000004_00000003_00000002_00000001,
                 128'h00000010_00000020_00000030_00000040, 128'h00000014_00000023_00000032_00000041};
      tbl[4] = '{VALU_VADD, VSEW_32, 128'h11111111_22222222_33333333_44444444,
                 128'h01010101_02020202_03030303_04040404, 128'h12121212_24242424_36363636_48484848};
      tbl[5] = '{VALU_VXOR, VSEW_32, {4{32'hAAAA5555}}, {4{32'hFFFF0000}}, {4{32'h55555555}}};
      for (int i = 6; i < NVEC; i++) begin
         tbl[i].op  = 4'($urandom_range(0, 4));
         tbl[i].sew = 2'($urandom_range(0, 2));
         tbl[i].a   = {$urandom, $urandom, $urandom, $urandom};
         tbl[i].b   = {$urandom, $urandom, $urandom, $urandom};
         tbl[i].exp = vec_model(tbl[i].op, tbl[i].sew, tbl[i].a, tbl[i].b);
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset vd_data", vd_data, '0);
      chk_int("reset busy", busy, 0);
      chk_int("reset done", done, 0);
      chk_int("reset alu_op_A", alu_op_A, 0);
      chk_int("reset alu_op_B", alu_op_B, 0);
      chk_int("reset alu_op_instr", alu_op_instr, 0);
      chk_int("reset alu_vsew", alu_vsew, 0);
      nrst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++)
         run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].sew, tbl[i].a, tbl[i].b, tbl[i].exp);

      // start while busy is ignored
      op_instr = VALU_VSUB; vsew = VSEW_32;
      vs2_data = {4{32'h00000100}}; vs1_data = {4{32'h00000001}};
      start = 1'b1;
      exp_q.push_back({4{32'h000000FF}});
      @(negedge clk);   // cycle 1
      start = 1'b0;
      @(negedge clk);   // cycle 2
      op_instr = VALU_VOR; vs2_data = '1; vs1_data = '1;
      start = 1'b1;
      @(negedge clk);   // cycle 3
      start = 1'b0;
      chk_int("ignored op_instr_kept", alu_op_instr, VALU_VSUB);
      watch("ignored", 0, 3, 8, 1);
      @(negedge clk);

      // Reset in the middle of an add
      op_instr = VALU_VADD; vsew = VSEW_32;
      vs2_data = {4{32'h00000007}}; vs1_data = {4{32'h00000001}};
      start = 1'b1;
      exp_q.push_back({4{32'h00000008}});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);   // mid cycle 3
      nrst = 1'b0;
      #1;
      chk_int("midreset busy", busy, 0);
      chk_int("midreset done", done, 0);
      chk("midreset vd_data", vd_data, '0);
      chk_int("midreset alu_op_A", alu_op_A, 0);
      chk_int("midreset alu_op_B", alu_op_B, 0);
      exp_q.delete();
      @(negedge clk);
      nrst = 1'b1;
      n_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk_int("midreset no_done_after", n_done, 0);
      chk("midreset vd_data_after", vd_data, '0);

      // Back-to-back XOR ops, second started in the first's done cycle
      op_instr = VALU_VXOR; vsew = VSEW_32;
      vs2_data = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      vs1_data = {4{32'h0F0F0F0F}};
      start = 1'b1;
      exp_q.push_back(128'h0E2C4A68_86A4C2E0_F1D3B597_795B3D1F);
      @(negedge clk);
      start = 1'b0;
      watch("b2b_first", 0, 1, 5, 0);
      vs2_data = {4{32'h12345678}};
      vs1_data = {4{32'hFFFFFFFF}};
      start = 1'b1;
      exp_q.push_back({4{32'hEDCBA987}});
      @(negedge clk);   // cycle 6
      start = 1'b0;
      chk("b2b first_result_stable", vd_data, 128'h0E2C4A68_86A4C2E0_F1D3B597_795B3D1F);
      watch("b2b_second", 5, 6, 12, 0);
      @(negedge clk);

`ifdef V_ALU_SEQ_SCALAR_EN
      scalar_sel = 1'b1;
      rs1_data = 32'h00000003;
      run_vec("scalar_vsub16", VALU_VSUB, VSEW_16, {8{16'h0010}}, {4{32'hDEADBEEF}}, {8{16'h000D}});
      rs1_data = 32'h00000105;
      run_vec("scalar_vadd8", VALU_VADD, VSEW_8, {16{8'h10}}, {4{32'h12345678}}, {16{8'h15}});
      scalar_sel = 1'b0;
`endif

      chk_int("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/v_alu_seq.md
# v_alu_seq

Operand sequencer sitting directly upstream of the VALU. It accepts full vector-register operands (VECTOR_LENGTH bits) and issues them to the VALU one VALU_OP_W_MAX-bit chunk per cycle. It tracks the VALU's per-operation result latency, reassembles the returned chunks into a full destination vector, and pulses `done` when the vector is complete.

## Interface
Parameters:
- VECTOR_LENGTH, 128, vector register width in bits; must be a multiple of VALU_OP_W_MAX.
- VALU_OP_W_MAX, 32, VALU operand width; fixed at 32 because VALU lane slicing is hard-wired.
- ADDSUB_LAT, 1, VALU result latency in cycles for VALU_VADD/VALU_VSUB (registered adder IP). All other ops have latency 0.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- op_instr  in  4  VALU opcode (v_pkg VALU_* encoding).
- vsew  in  2  element width (v_pkg VSEW_8/16/32).
- vs2_data  in  VECTOR_LENGTH  operand A vector.
- vs1_data  in  VECTOR_LENGTH  operand B vector.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse; vd_data complete.
- vd_data  out  VECTOR_LENGTH  assembled result.
- alu_op_instr  out  4  to VALU op_instr.
- alu_vsew  out  2  to VALU vsew.
- alu_op_A  out  VALU_OP_W_MAX  to VALU op_A.
- alu_op_B  out  VALU_OP_W_MAX  to VALU op_B.
- alu_result  in  VALU_OP_W_MAX  from VALU result.

## Operation
- N = VECTOR_LENGTH/VALU_OP_W_MAX chunks; chunk k = bits [k*32+31 : k*32].
- L = ADDSUB_LAT when the latched op is VALU_VADD or VALU_VSUB, else 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on start=1, latch op_instr, vsew, vs2_data and vs1_data; clear issue_idx and cap_idx; go to ISSUE.
  - ISSUE: drive chunk issue_idx on alu_op_A/alu_op_B, then increment issue_idx. After chunk N-1 is issued, go to DRAIN if L>0, else go to IDLE.
  - DRAIN: count L cycles, driving alu_op_A/B = 0, then go to IDLE.
- alu_op_instr/alu_vsew carry the latched values and are held through ISSUE and DRAIN, so the VALU's CE stays high while the adder pipeline drains. In IDLE they retain their last value.
- alu_op_A/B are 0 outside ISSUE.
- Capture: an L-deep valid shift register follows issue. When a valid entry emerges, alu_result is written into vd_data chunk cap_idx and cap_idx increments. When L=0, capture happens in the same cycle as issue.
- done is registered. It is set on the capture of chunk N-1 and cleared the following cycle.
- vd_data chunks change only on capture; previous contents persist until they are overwritten.
- start while busy=1: ignored, with no side effects.
- busy is already 0 in the done cycle, so a start in that cycle is accepted (back-to-back operation). The first capture of the new op happens no earlier than the end of the next cycle, so vd_data is stable during done.
- nrst low: asynchronously clears state to IDLE, all counters, busy, done, vd_data, alu_op_instr, alu_vsew and alu_op_A/B to 0. An operation interrupted by reset never produces done.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- Issue occurs in cycles 1..N; chunk k is issued in cycle k+1.
- Chunk k is captured at the end of cycle k+1+L.
- done is high in cycle N+L+1: cycle 5 for logic/shift/min/max ops, cycle 6 for add/sub (N=4, ADDSUB_LAT=1).
- busy is high in cycles 1..N+L.
- Issue throughput: one chunk per cycle, with no bubbles.

## Configuration
- V_ALU_SEQ_SCALAR_EN defined:
  - Adds ports `scalar_sel in 1` and `rs1_data in 32`, both latched on start.
  - When scalar_sel=1, every chunk's operand B is rs1 replicated per vsew: {4{rs1[7:0]}}, {2{rs1[15:0]}}, or rs1.
  - vs1_data is ignored in that case.
- Undefined: these ports are absent and operand B always comes from vs1_data.

## Test plan
- VADD, VSEW_8: vs2 all bytes 0x01, vs1 all bytes 0x02 -> vd_data = 128'h0303…03; done in cycle 6 only; busy high in cycles 1–5.
- VAND, VSEW_32: vs2 = {4{32'hFFFF0000}}, vs1 = {4{32'h0F0F0F0F}} -> vd_data = {4{32'h0F0F0000}}; done in cycle 5.
- VSUB in progress, start re-asserted in cycle 2 with VOR -> ignored; exactly one done (cycle 6) with the VSUB result.
- nrst pulsed low mid-cycle 3 of a VADD -> busy, done, vd_data and alu_op_A/B are 0 immediately; no done afterwards.
- VXOR with start in cycle 0, then a second VXOR started in its done cycle (cycle 5) -> second done in cycle 10; first result stable during cycle 5.
- With V_ALU_SEQ_SCALAR_EN: VSUB, VSEW_16, vs2 = {8{16'h0010}}, scalar_sel=1, rs1 = 32'h00000003 -> vd_data = {8{16'h000D}}.
